puf_challenge_sequencer: RTL and testbench
==========================================

Name: puf_challenge_sequencer

Overview:
- Downstream/control stage for the 16-ring-oscillator PUF core; replaces manual VIO driving of its selects, enable and reset.
- Walks a latched challenge of N_BITS oscillator pairs. For each pair it clears the PUF counters, runs one measurement window, then samples the PUF output bit through a synchronizer.
- Assembles an N_BITS response word and reports completion to the host/VIO side.

Parameters:
- N_BITS, 8, number of oscillator pairs per challenge (response width).
- WINDOW, 4096, clock cycles ro_enable is held high per pair; must be at least the PUF clock-counter saturation time (4095).
- RST_CYC, 4, clock cycles ro_reset is held high before each measurement.
- HOLD_CYC, 4, extra cycles after WINDOW with enable still high, so the stopped counters and the synchronizer settle; minimum 3.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- challenge  in  8*N_BITS  pair k: bits [8k+3:8k] = select1 index, [8k+7:8k+4] = select2 index
- puf_bit  in  1  PUF comparator output (counter1 >= counter2); asynchronous to clock
- ro_select1  out  4  mux1 select to PUF
- ro_select2  out  4  mux2 select to PUF
- ro_enable  out  1  PUF enable
- ro_reset  out  1  PUF counter reset
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when response is complete
- response  out  N_BITS  bit k = result of pair k
- invalid_mask  out  N_BITS  bit k = 1 if pair k had select1 == select2

Behaviour:
Reset values:
- State IDLE, ro_reset=1, ro_enable=0, selects=0, busy=0, done=0, response=0, invalid_mask=0, pair index=0, synchronizer flops=0.

Synchronizer:
- puf_bit passes through a 2-flop synchronizer on clock. Only the synchronized value is ever captured.

FSM states: IDLE, LOAD, CLEAR, MEASURE, HOLD, CAPTURE, FINISH.
- IDLE: ro_reset=1, ro_enable=0. start=1 → latch challenge, clear response and invalid_mask, index=0, go to LOAD.
- LOAD: drive selects from pair[index]. If select1 == select2: set invalid_mask[index]=1, response[index]=0, go to CAPTURE without measuring (1 cycle). Otherwise go to CLEAR.
- CLEAR: ro_reset=1, ro_enable=0 for exactly RST_CYC cycles, then go to MEASURE.
- MEASURE: ro_reset=0, ro_enable=1 for exactly WINDOW cycles, then go to HOLD.
- HOLD: ro_enable=1 for HOLD_CYC cycles. On the last HOLD cycle, response[index] is written from the synchronized puf_bit. Then go to CAPTURE.
- CAPTURE: if index == N_BITS-1 go to FINISH; else index+1, go to LOAD.
- FINISH: done=1 for one cycle, ro_reset=1, ro_enable=0, go to IDLE.

Output rules:
- Selects are stable from LOAD through CAPTURE of each pair and never change while ro_enable=1.
- Selects hold their last value in IDLE.
- Valid-pair cost is 1+RST_CYC+WINDOW+HOLD_CYC+1 cycles. Invalid-pair cost is 2 cycles.
- busy=1 in every state except IDLE; it drops in the same cycle that done pulses.
- response and invalid_mask are undefined-free: bits not yet processed read 0. Both hold after done until the next accepted start.
- start while busy is ignored (no queueing). start in the same cycle as done/FINISH is ignored.
- challenge is latched at start; later changes have no effect on the run in progress.

Asynchronous reset mid-run:
- Immediate return to reset values, including ro_reset=1.
- No done pulse; the partial response is discarded.

Index counter width is clog2(N_BITS), minimum 1. It does not wrap within a run.

Test Plan:
Use N_BITS=4, WINDOW=16, RST_CYC=2, HOLD_CYC=3, and a PUF model that returns a fixed bit per (select1,select2).
1. Model (0,1)→1, (2,3)→0, (4,5)→1, (6,7)→1; challenge pairs in that order; one start pulse → done after 4×23+1 cycles, response=4'b1101, invalid_mask=0, ro_enable high exactly 19 cycles per pair.
2. Pair 2 = (5,5), others valid → invalid_mask=4'b0100, response[2]=0, pair 2 never raises ro_enable, total run 21 cycles shorter than scenario 1.
3. Second start pulse during MEASURE of pair 1 plus challenge changed mid-run → ignored; response equals that of the originally latched challenge; exactly one done.
4. Assert reset in HOLD of pair 3 → next cycle ro_reset=1, ro_enable=0, busy=0, response=0, no done; a new start then completes normally.
5. Model toggles puf_bit during MEASURE but holds it stable from the end of WINDOW → captured bit equals the stable value; ro_reset is high during CLEAR of every pair and in IDLE.
6. All four pairs invalid → done 4×2+1 cycles after start, invalid_mask=4'b1111, response=0, ro_enable never asserted.

Source files
------------

// File: rtl/puf_challenge_sequencer.sv
// Challenge sequencer for the ring-oscillator PUF: walks N_BITS oscillator pairs,
// times clear/measure/hold per pair and assembles the synchronized response word.
module puf_challenge_sequencer #(
  parameter int unsigned N_BITS   = 8,
  parameter int unsigned WINDOW   = 4096,
  parameter int unsigned RST_CYC  = 4,
  parameter int unsigned HOLD_CYC = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [8*N_BITS-1:0]   i_challenge,
  input  logic                  i_puf_bit,
  output logic [3:0]            o_ro_select1,
  output logic [3:0]            o_ro_select2,
  output logic                  o_ro_enable,
  output logic                  o_ro_reset,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [N_BITS-1:0]     o_response,
  output logic [N_BITS-1:0]     o_invalid_mask
);

  localparam int unsigned IdxW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int unsigned CntW = $clog2(WINDOW + RST_CYC + HOLD_CYC + 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StClear, StMeasure, StHold, StCapture, StFinish
  } state_e;

  state_e                r_state, w_state_next;
  logic [8*N_BITS-1:0]   r_chal;
  logic [IdxW-1:0]       r_idx;
  logic [CntW-1:0]       r_cnt;
  logic [3:0]            r_sel1, r_sel2;
  logic [N_BITS-1:0]     r_resp, r_mask;
  logic                  r_sync1, r_sync2;

  logic                  w_cnt_last;
  logic                  w_timed;
  logic                  w_last_pair;
  logic [8*N_BITS-1:0]   w_chal_shift;

  // The latched challenge shifts down one pair per step, so the current pair is always byte 0.
  assign w_chal_shift = r_chal >> 8;
  assign w_last_pair  = (r_idx == IdxW'(N_BITS - 1));
  assign w_timed      = (r_state == StClear) || (r_state == StMeasure) || (r_state == StHold);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_last   = 1'b0;
    o_ro_reset   = 1'b1;
    o_ro_enable  = 1'b0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_busy = 1'b0;
        if (i_start) w_state_next = StLoad;
      end
      StLoad: w_state_next = (r_sel1 == r_sel2) ? StCapture : StClear;
      StClear: begin
        w_cnt_last = (r_cnt == CntW'(RST_CYC - 1));
        if (w_cnt_last) w_state_next = StMeasure;
      end
      StMeasure: begin
        o_ro_reset  = 1'b0;
        o_ro_enable = 1'b1;
        w_cnt_last  = (r_cnt == CntW'(WINDOW - 1));
        if (w_cnt_last) w_state_next = StHold;
      end
      StHold: begin
        o_ro_reset  = 1'b0;
        o_ro_enable = 1'b1;
        w_cnt_last  = (r_cnt == CntW'(HOLD_CYC - 1));
        if (w_cnt_last) w_state_next = StCapture;
      end
      StCapture: w_state_next = w_last_pair ? StFinish : StLoad;
      StFinish: begin
        o_done       = 1'b1;
        o_busy       = 1'b0;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_chal  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_sel1  <= '0;
      r_sel2  <= '0;
      r_resp  <= '0;
      r_mask  <= '0;
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_puf_bit;
      r_sync2 <= r_sync1;
      r_cnt   <= (w_cnt_last || !w_timed) ? '0 : r_cnt + 1'b1;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_chal <= i_challenge;
            r_sel1 <= i_challenge[3:0];
            r_sel2 <= i_challenge[7:4];
            r_idx  <= '0;
            r_resp <= '0;
            r_mask <= '0;
          end
        end
        StLoad: begin
          if (r_sel1 == r_sel2) begin
            r_mask[r_idx] <= 1'b1;
            r_resp[r_idx] <= 1'b0;
          end
        end
        // Counters have stopped by the last hold cycle; only the synchronized bit is used.
        StHold: begin
          if (w_cnt_last) r_resp[r_idx] <= r_sync2;
        end
        StCapture: begin
          if (!w_last_pair) begin
            r_idx  <= r_idx + 1'b1;
            r_chal <= w_chal_shift;
            r_sel1 <= w_chal_shift[3:0];
            r_sel2 <= w_chal_shift[7:4];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ro_select1   = r_sel1;
  assign o_ro_select2   = r_sel2;
  assign o_response     = r_resp;
  assign o_invalid_mask = r_mask;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer: fixed and random challenges against a per-pair
// cost/result model, with a lookup-table PUF and a monitor on enable/reset/select behaviour.
module tb_puf_challenge_sequencer;
  localparam int N = 4;
  localparam int W = 16;
  localparam int R = 2;
  localparam int H = 3;
  localparam int PairCyc = 1 + R + W + H + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] chal;
  logic        puf = 1'b0;
  logic [3:0]  sel1, sel2;
  logic        ro_en, ro_rst, busy, done;
  logic [3:0]  resp, mask;

  puf_challenge_sequencer #(.N_BITS(N), .WINDOW(W), .RST_CYC(R), .HOLD_CYC(H)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_challenge(chal), .i_puf_bit(puf),
    .o_ro_select1(sel1), .o_ro_select2(sel2), .o_ro_enable(ro_en), .o_ro_reset(ro_rst),
    .o_busy(busy), .o_done(done), .o_response(resp), .o_invalid_mask(mask)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  bit tab [256];
  bit toggle_mode = 1'b0;
  int en_cnt = 0;

  // PUF model: fixed bit per (select1, select2); optionally noisy during the window only.
  always @(negedge clk) begin
    if (ro_en) en_cnt++; else en_cnt = 0;
    if (toggle_mode && ro_en && en_cnt <= W) puf = ($urandom_range(0, 1) == 1);
    else puf = tab[{sel2, sel1}];
  end

  int         en_len = 0, done_cnt = 0, sel_viol = 0, clr_viol = 0, both_viol = 0, idle_viol = 0;
  int         en_lens[$];
  logic       prev_en = 1'b0;
  logic [3:0] p1 = 4'd0, p2 = 4'd0;
  logic [1:0] rst_hist = 2'b00;

  always @(negedge clk) begin
    if (ro_en) begin
      if (prev_en && (sel1 !== p1 || sel2 !== p2)) sel_viol++;
      if (!prev_en && rst_hist !== 2'b11) clr_viol++;
      if (ro_rst) both_viol++;
      en_len++;
    end else if (prev_en) begin
      en_lens.push_back(en_len);
      en_len = 0;
    end
    if (!busy && !done && !ro_rst) idle_viol++;
    if (done) done_cnt++;
    rst_hist = {rst_hist[0], ro_rst};
    prev_en  = ro_en;
    p1 = sel1;
    p2 = sel2;
  end

  task automatic clear_mon();
    en_lens.delete();
    en_len = 0; done_cnt = 0; sel_viol = 0; clr_viol = 0; both_viol = 0; idle_viol = 0;
  endtask

  function automatic void model(input logic [31:0] c, output logic [3:0] r,
                                output logic [3:0] m, output int cyc, output int nv);
    logic [3:0] s1, s2;
    r = '0; m = '0; cyc = 1; nv = 0;
    for (int k = 0; k < N; k++) begin
      s1 = c[8*k +: 4];
      s2 = c[8*k+4 +: 4];
      if (s1 == s2) begin
        m[k] = 1'b1;
        cyc += 2;
      end else begin
        r[k] = tab[{s2, s1}];
        cyc += PairCyc;
        nv++;
      end
    end
  endfunction

  function automatic logic [31:0] rand_chal(input bool_inv);
    logic [31:0] c;
    logic [3:0]  s1;
    for (int k = 0; k < N; k++) begin
      s1 = 4'($urandom_range(0, 15));
      c[8*k +: 4] = s1;
      if (bool_inv && $urandom_range(0, 3) == 0) c[8*k+4 +: 4] = s1;
      else c[8*k+4 +: 4] = s1 ^ 4'($urandom_range(1, 15));
    end
    return c;
  endfunction

  // Cycle 1 is the first cycle after the accepting edge; returns -1 on timeout.
  task automatic run(input logic [31:0] c, input int inj_cyc, input logic [31:0] inj_c,
                     output int cyc);
    clear_mon();
    @(negedge clk); start = 1'b1; chal = c;
    @(negedge clk); start = 1'b0; cyc = 1;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == inj_cyc);
      if (cyc == inj_cyc) chal = inj_c;
    end
    if (!done) cyc = -1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; chal = '0;
    repeat (2) @(negedge clk);
    n_vec++; if (ro_rst !== 1'b1) begin n_fail++; $display("FAIL rst_ro_reset got %b want 1", ro_rst); end
    n_vec++; if (ro_en !== 1'b0) begin n_fail++; $display("FAIL rst_ro_enable got %b want 0", ro_en); end
    n_vec++; if ({sel2, sel1} !== 8'h00) begin
      n_fail++; $display("FAIL rst_selects got %h want 00", {sel2, sel1}); end
    n_vec++; if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL rst_busy_done got %b want 00", {busy, done}); end
    n_vec++; if ({resp, mask} !== 8'h00) begin
      n_fail++; $display("FAIL rst_resp_mask got %h want 00", {resp, mask}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fixed_pairs();
    int cyc, bad;
    run(32'h7654_3210, 0, '0, cyc);
    bad = 0;
    foreach (en_lens[i]) if (en_lens[i] != W + H) bad++;
    n_vec++; if (cyc !== 4 * 23 + 1) begin n_fail++; $display("FAIL fixed_cycles got %0d want 93", cyc); end
    n_vec++; if (resp !== 4'b1101) begin n_fail++; $display("FAIL fixed_resp got %b want 1101", resp); end
    n_vec++; if (mask !== 4'b0000) begin n_fail++; $display("FAIL fixed_mask got %b want 0000", mask); end
    n_vec++; if (en_lens.size() != 4 || bad != 0) begin
      n_fail++; $display("FAIL fixed_enable_len windows %0d bad %0d want 4/0", en_lens.size(), bad); end
    n_vec++; if (done_cnt != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL fixed_done dones %0d busy %b want 1/0", done_cnt, busy); end
    n_vec++; if (sel_viol + both_viol + clr_viol != 0) begin
      n_fail++; $display("FAIL fixed_sel_stable viol %0d want 0", sel_viol + both_viol + clr_viol); end
  endtask

  task automatic test_invalid_pair();
    int cyc;
    run(32'h7655_3210, 0, '0, cyc);
    n_vec++; if (cyc !== 93 - 21) begin n_fail++; $display("FAIL inv_cycles got %0d want 72", cyc); end
    n_vec++; if (mask !== 4'b0100) begin n_fail++; $display("FAIL inv_mask got %b want 0100", mask); end
    n_vec++; if (resp !== 4'b1001) begin n_fail++; $display("FAIL inv_resp got %b want 1001", resp); end
    n_vec++; if (en_lens.size() != 3) begin
      n_fail++; $display("FAIL inv_enable_windows got %0d want 3", en_lens.size()); end
  endtask

  task automatic test_back_to_back();
    int cyc, ecyc, nv;
    logic [31:0] c;
    logic [3:0] er, em;
    c = rand_chal(1'b1);
    model(c, er, em, ecyc, nv);
    run(c, 30, ~c, cyc);
    n_vec++; if ({resp, mask} !== {er, em}) begin
      n_fail++; $display("FAIL b2b_resp got %b/%b want %b/%b", resp, mask, er, em); end
    n_vec++; if (cyc !== ecyc || done_cnt != 1) begin
      n_fail++; $display("FAIL b2b_cycles got %0d/%0d want %0d/1", cyc, done_cnt, ecyc); end
    c = rand_chal(1'b1);
    model(c, er, em, ecyc, nv);
    run(c, ecyc, rand_chal(1'b0), cyc);
    n_vec++; if (busy !== 1'b0 || done_cnt != 1) begin
      n_fail++; $display("FAIL start_at_done busy %b dones %0d want 0/1", busy, done_cnt); end
    n_vec++; if ({resp, mask} !== {er, em}) begin
      n_fail++; $display("FAIL start_at_done_resp got %b/%b want %b/%b", resp, mask, er, em); end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    clear_mon();
    @(negedge clk); start = 1'b1; chal = 32'h7654_3210;
    @(negedge clk); start = 1'b0; cyc = 1;
    while (cyc < 3 * 23 + 1 + R + W + 2) begin @(negedge clk); cyc++; end
    n_vec++; if ({ro_en, busy} !== 2'b11) begin
      n_fail++; $display("FAIL midrst_in_hold got %b want 11", {ro_en, busy}); end
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if ({ro_rst, ro_en, busy, done} !== 4'b1000) begin
      n_fail++; $display("FAIL midrst_ctrl got %b want 1000", {ro_rst, ro_en, busy, done}); end
    n_vec++; if ({resp, mask, sel2, sel1} !== 16'h0000) begin
      n_fail++; $display("FAIL midrst_data got %h want 0000", {resp, mask, sel2, sel1}); end
    n_vec++; if (done_cnt != 0) begin n_fail++; $display("FAIL midrst_done got %0d want 0", done_cnt); end
    rst = 1'b0;
    run(32'h7654_3210, 0, '0, cyc);
    n_vec++; if (cyc !== 93 || resp !== 4'b1101) begin
      n_fail++; $display("FAIL midrst_rerun got %0d/%b want 93/1101", cyc, resp); end
  endtask

  task automatic test_toggle();
    int cyc, ecyc, nv;
    logic [31:0] c;
    logic [3:0] er, em;
    toggle_mode = 1'b1;
    for (int t = 0; t < 3; t++) begin
      c = rand_chal(1'b0);
      model(c, er, em, ecyc, nv);
      run(c, 0, '0, cyc);
      n_vec++; if ({resp, mask} !== {er, em} || cyc !== ecyc) begin
        n_fail++; $display("FAIL toggle_resp got %b/%b/%0d want %b/%b/%0d",
                           resp, mask, cyc, er, em, ecyc); end
      n_vec++; if (clr_viol + idle_viol + both_viol + sel_viol != 0) begin
        n_fail++; $display("FAIL toggle_ro_reset clr %0d idle %0d both %0d sel %0d want 0",
                           clr_viol, idle_viol, both_viol, sel_viol); end
    end
    toggle_mode = 1'b0;
  endtask

  task automatic test_all_invalid();
    int cyc;
    run(32'h3322_1100, 0, '0, cyc);
    n_vec++; if (cyc !== 4 * 2 + 1) begin n_fail++; $display("FAIL allinv_cycles got %0d want 9", cyc); end
    n_vec++; if ({resp, mask} !== 8'h0F) begin
      n_fail++; $display("FAIL allinv_resp_mask got %b/%b want 0000/1111", resp, mask); end
    n_vec++; if (en_lens.size() != 0 || en_len != 0) begin
      n_fail++; $display("FAIL allinv_enable got %0d windows want 0", en_lens.size()); end
  endtask

  task automatic test_random();
    int cyc, ecyc, nv, bad;
    logic [31:0] c;
    logic [3:0] er, em;
    for (int t = 0; t < 6; t++) begin
      c = rand_chal(1'b1);
      model(c, er, em, ecyc, nv);
      run(c, 0, '0, cyc);
      bad = 0;
      foreach (en_lens[i]) if (en_lens[i] != W + H) bad++;
      n_vec++; if ({resp, mask} !== {er, em} || cyc !== ecyc) begin
        n_fail++; $display("FAIL rand_run chal %h got %b/%b/%0d want %b/%b/%0d",
                           c, resp, mask, cyc, er, em, ecyc); end
      n_vec++; if (en_lens.size() != nv || bad != 0 || done_cnt != 1) begin
        n_fail++; $display("FAIL rand_enable windows %0d bad %0d dones %0d want %0d/0/1",
                           en_lens.size(), bad, done_cnt, nv); end
    end
  endtask

  initial begin
    foreach (tab[i]) tab[i] = ($urandom_range(0, 1) == 1);
    tab[{4'd1, 4'd0}] = 1'b1;
    tab[{4'd3, 4'd2}] = 1'b0;
    tab[{4'd5, 4'd4}] = 1'b1;
    tab[{4'd7, 4'd6}] = 1'b1;
    test_reset();
    test_fixed_pairs();
    test_invalid_pair();
    test_back_to_back();
    test_reset_mid_run();
    test_toggle();
    test_all_invalid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
